// File: rtl/isa_capture_arbiter.sv
// Round-robin arbiter sharing the ISA->Pi capture ring write port; writes each granted
// event as an unsplit {tag, data} byte pair and requests CHRDY hold as the ring fills.
module isa_capture_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned AW         = 12,
  parameter int unsigned HIGH_WATER = 3968,
  parameter int unsigned WAIT_MAX   = 511
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_tag,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic [AW-1:0]     rd_ptr,
  output logic [AW-1:0]     wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic [AW-1:0]     level,
  output logic              chrdy_hold,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW      = $clog2(WAIT_MAX + 1);
  localparam int unsigned MAX_LVL = (2 ** AW) - 3;

  typedef enum logic [1:0] {IDLE, STALL, TAG, DATA} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   wr_ptr, wr_ptr_n;
  logic [IW-1:0]   rr_ptr, rr_n;
  logic [SW-1:0]   stall_cnt, stall_n;
  logic [IW-1:0]   win_q, win_n;
  logic [7:0]      tag_q, tag_n, data_q, data_n;
  logic [NREQ-1:0] ready_n;
  logic            wr_en_n;
  logic [AW-1:0]   wr_addr_n;
  logic [7:0]      wr_data_n;
  logic [AW-1:0]   level_n;
  logic            hold_n;
  logic [15:0]     drop_n;
  logic            drop_now;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [7:0]      sel_tag, sel_data;
  logic [AW-1:0]   level_c;
  logic            free_ok;
  int unsigned     scan;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = (32'(rr_ptr) + k) % NREQ;
      if (!win_found && req_valid[IW'(scan)]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan);
      end
    end
  end

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IW'(k) == win_idx) begin
        sel_tag  = req_tag[8*k +: 8];
        sel_data = req_data[8*k +: 8];
      end
    end
  end

  // One slot stays empty, so a pair fits only while level <= depth-3.
  assign level_c = wr_ptr - rd_ptr;
  assign free_ok = (level_c <= AW'(MAX_LVL));

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] i);
    return IW'((32'(i) + 1) % NREQ);
  endfunction

  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    rr_n      = rr_ptr;
    stall_n   = stall_cnt;
    win_n     = win_q;
    tag_n     = tag_q;
    data_n    = data_q;
    ready_n   = '0;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    drop_n    = drop_cnt;
    drop_now  = 1'b0;

    case (state)
      IDLE: begin
        stall_n = '0;
        if (win_found) begin
          if (free_ok) begin
            win_n   = win_idx;
            tag_n   = sel_tag;
            data_n  = sel_data;
            state_n = TAG;
          end else begin
            state_n = STALL;
          end
        end
      end
      STALL: begin
        if (!win_found) begin
          stall_n = '0;
          state_n = IDLE;
        end else if (free_ok) begin
          win_n   = win_idx;
          tag_n   = sel_tag;
          data_n  = sel_data;
          stall_n = '0;
          state_n = TAG;
        end else if (stall_cnt == SW'(WAIT_MAX - 1)) begin
          ready_n[win_idx] = 1'b1;
          drop_now         = 1'b1;
          if (drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
          rr_n    = rr_next(win_idx);
          stall_n = '0;
          state_n = IDLE;
        end else begin
          stall_n = stall_cnt + SW'(1);
        end
      end
      TAG: begin
        ready_n[win_q] = 1'b1;
        wr_en_n        = 1'b1;
        wr_addr_n      = wr_ptr;
        wr_data_n      = tag_q;
        wr_ptr_n       = wr_ptr + AW'(1);
        rr_n           = rr_next(win_q);
        state_n        = DATA;
      end
      DATA: begin
        wr_en_n   = 1'b1;
        wr_addr_n = wr_ptr;
        wr_data_n = data_q;
        wr_ptr_n  = wr_ptr + AW'(1);
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    level_n = wr_ptr_n - rd_ptr;
    hold_n  = !drop_now && ((level_n >= AW'(HIGH_WATER)) || (state_n == STALL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rr_ptr     <= '0;
      stall_cnt  <= '0;
      win_q      <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      req_ready  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      level      <= '0;
      chrdy_hold <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      rr_ptr     <= rr_n;
      stall_cnt  <= stall_n;
      win_q      <= win_n;
      tag_q      <= tag_n;
      data_q     <= data_n;
      req_ready  <= ready_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      level      <= level_n;
      chrdy_hold <= hold_n;
      drop_cnt   <= drop_n;
    end
  end

endmodule
